window_taps: RTL and testbench

Streaming 5-row column generator that sits directly upstream of the binary convolution stage. It accepts one signed 8-bit feature-map pixel per valid cycle in raster order, keeps the previous K-1 rows in line buffers, and emits the K vertically aligned pixels of the current column on `taps`. The convolution stage's horizontal shift registers then assemble the full KxK window from successive columns. It serves both conv layers: 28x28 input for layer 1, 12x12 input for layer 2.

---
 rtl/bnn_pkg.sv | 20 ++
 rtl/line_buffer.sv | 23 ++
 rtl/window_taps.sv | 114 +++++++++++
 tb/tb_window_taps.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and layer-select type for the BNN conv front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bnn_pkg;
   localparam int K      = 5;
   localparam int DW     = 8;
   localparam int NI_L1  = 28;
   localparam int NI_L2  = 12;
   localparam int NI_MAX = NI_L1;

   typedef enum logic {
      LAYER1 = 1'b0,
      LAYER2 = 1'b1
   } layer_t;

   // Row length of the feature map for a given layer.
   function automatic logic [4:0] ni_of(input layer_t layer);
      return (layer == LAYER2) ? 5'(NI_L2) : 5'(NI_L1);
   endfunction
endpackage

// File: rtl/line_buffer.sv
// One-row delay line: reads mem[ptr] combinationally and overwrites it with din.
// Latency: read is same-cycle; the written value reappears one row (Ni pixels) later.
// Backpressure: none, writes only when we is high.
module line_buffer #(
   parameter int DEPTH = 28,
   parameter int DW    = 8,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] ptr,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);
   logic [DW-1:0] mem [DEPTH];

   // Storage is never reset: stale rows are masked downstream by the valid flags.
   always_ff @(posedge clk) begin
      if (we) mem[ptr] <= din;
   end

   assign dout = mem[ptr];
endmodule

// File: rtl/window_taps.sv
// Streaming K-row column generator feeding the conv stage (optional WINDOW_TAPS_EDGE_MASK_EN zeroes rows above frame top).
// Latency: 1 cycle from accepted pixel to taps and flags.
// Backpressure: none, one pixel per din_valid cycle; stalls simply hold outputs.
module window_taps #(
   parameter int K      = bnn_pkg::K,
   parameter int DW     = bnn_pkg::DW,
   parameter int NI_MAX = bnn_pkg::NI_MAX
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            state,
   input  logic [DW-1:0]   din,
   input  logic            din_valid,
   output logic [K*DW-1:0] taps,
   output logic            taps_valid,
   output logic            win_valid,
   output logic [4:0]      col,
   output logic [4:0]      row,
   output logic            frame_done
);
   import bnn_pkg::*;

   localparam int CW = 5;

   // ptr doubles as the column of the next pixel; cnt_row is the row of the next pixel.
   logic [CW-1:0]   ptr;
   logic [CW-1:0]   cnt_row;
   logic [CW-1:0]   ni_q;
   logic [CW-1:0]   ni_cur;
   logic            first_px;
   logic            col_last;
   logic            row_last;
   logic            lb_we;
   logic [DW-1:0]   lb_in  [K-1];
   logic [DW-1:0]   lb_out [K-1];
   logic [K*DW-1:0] col_nxt;

   // Ni is taken from state only on the first pixel of a frame, otherwise the latched copy.
   assign first_px = (ptr == '0) && (cnt_row == '0);
   assign ni_cur   = first_px ? ni_of(layer_t'(state)) : ni_q;
   assign col_last = (ptr == ni_cur - 1'b1);
   assign row_last = (cnt_row == ni_cur - 1'b1);
   assign lb_we    = din_valid && !rst;

   // Chain of K-1 line buffers sharing the column pointer; lb(i) holds row r-1-i.
   for (genvar i = 0; i < K - 1; i++) begin : g_lb
      if (i == 0) begin : g_head
         assign lb_in[i] = din;
      end else begin : g_link
         assign lb_in[i] = lb_out[i-1];
      end
      line_buffer #(
         .DEPTH (NI_MAX),
         .DW    (DW),
         .AW    (CW)
      ) u_lb (
         .clk  (clk),
         .we   (lb_we),
         .ptr  (ptr),
         .din  (lb_in[i]),
         .dout (lb_out[i])
      );
   end

   // Assemble the column: current pixel in the low lane, oldest row in the high lane.
   always_comb begin
      col_nxt         = '0;
      col_nxt[DW-1:0] = din;
      for (int i = 0; i < K - 1; i++) begin
         col_nxt[(i+2)*DW-1 -: DW] = lb_out[i];
`ifdef WINDOW_TAPS_EDGE_MASK_EN
         if (int'(cnt_row) < i + 1) col_nxt[(i+2)*DW-1 -: DW] = '0;
`endif
      end
   end

   // Register the column and flags, and advance the raster counters on each accepted pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= '0;
         cnt_row    <= '0;
         ni_q       <= ni_of(LAYER1);
         taps       <= '0;
         taps_valid <= 1'b0;
         win_valid  <= 1'b0;
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
      end else begin
         taps_valid <= 1'b0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (din_valid) begin
            ni_q <= ni_cur;
            taps <= col_nxt;
            col  <= ptr;
            row  <= cnt_row;
`ifdef WINDOW_TAPS_EDGE_MASK_EN
            taps_valid <= 1'b1;
`else
            taps_valid <= (cnt_row >= CW'(K - 1));
`endif
            win_valid  <= (cnt_row >= CW'(K - 1)) && (ptr >= CW'(K - 1));
            frame_done <= col_last && row_last;
            if (col_last) begin
               ptr     <= '0;
               cnt_row <= row_last ? '0 : cnt_row + 1'b1;
            end else begin
               ptr <= ptr + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_window_taps.sv
// Directed bench for window_taps: fills, stall, mid-frame reset, back-to-back frames.
// Latency: expects taps/flags one cycle after each accepted pixel.
// Backpressure: none; stalls are driven by dropping din_valid.
module tb_window_taps;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        state = 1'b0;
   logic [7:0]  din = '0;
   logic        din_valid = 1'b0;
   logic [39:0] taps;
   logic        taps_valid;
   logic        win_valid;
   logic [4:0]  col;
   logic [4:0]  row;
   logic        frame_done;

   int total = 0;
   int bad   = 0;

`ifdef WINDOW_TAPS_EDGE_MASK_EN
   localparam bit MASK = 1'b1;
`else
   localparam bit MASK = 1'b0;
`endif

   // Per-frame statistics filled in by run_frame.
   int          n_tv, n_wv, n_fd, fd_idx, first_tv_idx, first_wv_idx, rc_err;
   logic [39:0] first_tv_taps, first_wv_taps;

   window_taps dut (
      .clk        (clk),
      .rst        (rst),
      .state      (state),
      .din        (din),
      .din_valid  (din_valid),
      .taps       (taps),
      .taps_valid (taps_valid),
      .win_valid  (win_valid),
      .col        (col),
      .row        (row),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [7:0] v);
      din       = v;
      din_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      din_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Streams raster pixels first..last of an ni x ni frame, p(r,c) = (r*ni + c) mod 256.
   task automatic run_frame(input int ni, input logic st, input int toggle_at,
                            input int first, input int last);
      int r, c;
      logic [7:0] v;
      n_tv = 0; n_wv = 0; n_fd = 0; fd_idx = -1; rc_err = 0;
      first_tv_idx = -1; first_wv_idx = -1;
      first_tv_taps = '0; first_wv_taps = '0;
      for (int idx = first; idx <= last; idx++) begin
         r = idx / ni;
         c = idx % ni;
         v = 8'((r * ni + c) % 256);
         state = (toggle_at >= 0 && idx >= toggle_at) ? ~st : st;
         push(v);
         if (taps_valid) begin
            n_tv++;
            if (first_tv_idx < 0) begin first_tv_idx = idx; first_tv_taps = taps; end
         end
         if (win_valid) begin
            n_wv++;
            if (first_wv_idx < 0) begin first_wv_idx = idx; first_wv_taps = taps; end
         end
         if (frame_done) begin n_fd++; fd_idx = idx; end
         if (row !== 5'(r) || col !== 5'(c) || taps[7:0] !== v) rc_err++;
      end
      din_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; din_valid = 1'b1; din = 8'h55; state = 1'b0;
      @(posedge clk);
      #1;
      total++; if (taps !== 40'h0) begin bad++; $display("FAIL rst_taps got=%h want=0", taps); end
      total++; if ({taps_valid, win_valid, frame_done} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {taps_valid, win_valid, frame_done}); end
      total++; if (row !== 5'd0 || col !== 5'd0) begin bad++; $display("FAIL rst_rowcol got=%0d,%0d want=0,0", row, col); end
      rst = 1'b0; din_valid = 1'b0;
      @(posedge clk);
      #1;
      total++; if (taps !== 40'h0) begin bad++; $display("FAIL rst_drop got=%h want=0", taps); end
      push(8'h7E);
      din_valid = 1'b0;
      total++; if (taps[7:0] !== 8'h7E || row !== 5'd0 || col !== 5'd0) begin bad++; $display("FAIL rst_first_px got=%h@%0d,%0d want=7e@0,0", taps[7:0], row, col); end
      total++; if (taps_valid !== MASK) begin bad++; $display("FAIL rst_first_tv got=%b want=%b", taps_valid, MASK); end
   endtask

   task automatic test_layer2_fill();
      do_reset();
      run_frame(12, 1'b1, -1, 0, 143);
      total++; if (first_tv_idx !== (MASK ? 0 : 48)) begin bad++; $display("FAIL l2_first_tv_idx got=%0d want=%0d", first_tv_idx, MASK ? 0 : 48); end
      total++; if (first_tv_taps !== (MASK ? 40'h0 : 40'h000C182430)) begin bad++; $display("FAIL l2_first_tv_taps got=%h", first_tv_taps); end
      total++; if (first_wv_idx !== 52) begin bad++; $display("FAIL l2_first_wv_idx got=%0d want=52", first_wv_idx); end
      total++; if (first_wv_taps !== 40'h04101C2834) begin bad++; $display("FAIL l2_first_wv_taps got=%h want=04101c2834", first_wv_taps); end
      total++; if (n_fd !== 1 || fd_idx !== 143) begin bad++; $display("FAIL l2_frame_done got=%0d@%0d want=1@143", n_fd, fd_idx); end
      total++; if (n_tv !== (MASK ? 144 : 96)) begin bad++; $display("FAIL l2_tv_count got=%0d want=%0d", n_tv, MASK ? 144 : 96); end
      total++; if (n_wv !== 64) begin bad++; $display("FAIL l2_wv_count got=%0d want=64", n_wv); end
      total++; if (rc_err !== 0) begin bad++; $display("FAIL l2_rowcol got=%0d errors want=0", rc_err); end
   endtask

   task automatic test_layer1_fill();
      do_reset();
      run_frame(28, 1'b0, -1, 0, 783);
      total++; if (first_tv_idx !== (MASK ? 0 : 112)) begin bad++; $display("FAIL l1_first_tv_idx got=%0d want=%0d", first_tv_idx, MASK ? 0 : 112); end
      total++; if (first_tv_taps !== (MASK ? 40'h0 : 40'h001C385470)) begin bad++; $display("FAIL l1_first_tv_taps got=%h", first_tv_taps); end
      total++; if (n_tv !== (MASK ? 784 : 672)) begin bad++; $display("FAIL l1_tv_count got=%0d want=%0d", n_tv, MASK ? 784 : 672); end
      total++; if (n_wv !== 576) begin bad++; $display("FAIL l1_wv_count got=%0d want=576", n_wv); end
      total++; if (n_fd !== 1 || fd_idx !== 783) begin bad++; $display("FAIL l1_frame_done got=%0d@%0d want=1@783", n_fd, fd_idx); end
      total++; if (rc_err !== 0) begin bad++; $display("FAIL l1_rowcol got=%0d errors want=0", rc_err); end
   endtask

   task automatic test_stall();
      do_reset();
      run_frame(12, 1'b1, -1, 0, 77);
      // Column of (6,5): rows 2..6 at col 5 = 29,41,53,65,77.
      total++; if (taps !== 40'h1D2935414D) begin bad++; $display("FAIL stall_pre_taps got=%h want=1d2935414d", taps); end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         total++;
         if (taps !== 40'h1D2935414D || row !== 5'd6 || col !== 5'd5 ||
             {taps_valid, win_valid, frame_done} !== 3'b000) begin
            bad++;
            $display("FAIL stall_hold cyc=%0d got=%h %0d,%0d flags=%b want=1d2935414d 6,5 000",
                     k, taps, row, col, {taps_valid, win_valid, frame_done});
         end
      end
      state = 1'b1;
      push(8'd78);
      din_valid = 1'b0;
      // Column of (6,6): rows 2..6 at col 6 = 30,42,54,66,78.
      total++; if (taps !== 40'h1E2A36424E) begin bad++; $display("FAIL stall_resume_taps got=%h want=1e2a36424e", taps); end
      total++; if (row !== 5'd6 || col !== 5'd6 || win_valid !== 1'b1) begin bad++; $display("FAIL stall_resume_pos got=%0d,%0d wv=%b want=6,6 wv=1", row, col, win_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      run_frame(12, 1'b1, -1, 0, 59);
      do_reset();
      total++;
      if (taps !== 40'h0 || row !== 5'd0 || col !== 5'd0 || {taps_valid, win_valid, frame_done} !== 3'b000) begin
         bad++;
         $display("FAIL midrst_clear got=%h %0d,%0d flags=%b want=0 0,0 000", taps, row, col, {taps_valid, win_valid, frame_done});
      end
      run_frame(12, 1'b1, -1, 0, 143);
      total++; if (first_tv_idx !== (MASK ? 0 : 48)) begin bad++; $display("FAIL midrst_first_tv_idx got=%0d want=%0d", first_tv_idx, MASK ? 0 : 48); end
      total++; if (first_tv_taps !== (MASK ? 40'h0 : 40'h000C182430)) begin bad++; $display("FAIL midrst_first_tv_taps got=%h", first_tv_taps); end
      total++; if (n_fd !== 1 || fd_idx !== 143 || rc_err !== 0) begin bad++; $display("FAIL midrst_frame got=%0d@%0d rc=%0d want=1@143 rc=0", n_fd, fd_idx, rc_err); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      // state flips to 0 at pixel 30; this frame must keep Ni=12.
      run_frame(12, 1'b1, 30, 0, 143);
      total++; if (n_fd !== 1 || fd_idx !== 143) begin bad++; $display("FAIL b2b_f1_done got=%0d@%0d want=1@143", n_fd, fd_idx); end
      total++; if (n_tv !== (MASK ? 144 : 96) || n_wv !== 64) begin bad++; $display("FAIL b2b_f1_counts got=%0d/%0d", n_tv, n_wv); end
      total++; if (rc_err !== 0) begin bad++; $display("FAIL b2b_f1_rowcol got=%0d errors want=0", rc_err); end
      // No idle cycle: the next frame starts on the very next edge with Ni=28.
      run_frame(28, 1'b0, -1, 0, 783);
      total++; if (n_fd !== 1 || fd_idx !== 783) begin bad++; $display("FAIL b2b_f2_done got=%0d@%0d want=1@783", n_fd, fd_idx); end
      total++; if (n_tv !== (MASK ? 784 : 672) || n_wv !== 576) begin bad++; $display("FAIL b2b_f2_counts got=%0d/%0d", n_tv, n_wv); end
      total++; if (rc_err !== 0) begin bad++; $display("FAIL b2b_f2_rowcol got=%0d errors want=0", rc_err); end
      total++; if (first_tv_taps !== (MASK ? 40'h0 : 40'h001C385470)) begin bad++; $display("FAIL b2b_f2_first_taps got=%h", first_tv_taps); end
   endtask

`ifdef WINDOW_TAPS_EDGE_MASK_EN
   task automatic test_edge_mask();
      do_reset();
      run_frame(12, 1'b1, -1, 0, 3);
      total++; if (taps !== 40'h0000000003 || taps_valid !== 1'b1) begin bad++; $display("FAIL mask_r0c3 got=%h tv=%b want=0000000003 tv=1", taps, taps_valid); end
      run_frame(12, 1'b1, -1, 4, 24);
      total++; if (taps !== 40'h0000000C18 || taps_valid !== 1'b1) begin bad++; $display("FAIL mask_r2c0 got=%h tv=%b want=0000000c18 tv=1", taps, taps_valid); end
   endtask
`endif

   initial begin
      test_reset();
      test_layer2_fill();
      test_layer1_fill();
      test_stall();
      test_reset_mid();
      test_back_to_back();
`ifdef WINDOW_TAPS_EDGE_MASK_EN
      test_edge_mask();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
